// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter: FSM state encoding and grant codes.
// Used by mem_port_arbiter and mem_arb_pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_XFER = 2'd1,
        DM_XFER = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// FAIR_ARB_EN: alternate on contention using the last grant; otherwise data side always wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_dm_req,
`ifdef FAIR_ARB_EN
    input  grant_t i_last_grant,
`endif
    output logic   o_any,
    output grant_t o_grant
);

    always_comb begin
        o_any   = i_if_req | i_dm_req;
        o_grant = GRANT_DM;
        if (i_if_req && !i_dm_req) begin
            o_grant = GRANT_IF;
        end
`ifdef FAIR_ARB_EN
        else if (i_if_req && i_dm_req && (i_last_grant == GRANT_DM)) begin
            o_grant = GRANT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and data access.
// Optional macro FAIR_ARB_EN switches contention handling from fixed data priority to alternating.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall
);

    state_t              r_state;
    state_t              w_state_next;
    logic                w_any;
    grant_t              w_grant;
    logic                w_grant_load;
    logic                w_xfer_done;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_if_ready;
    logic                r_dm_ready;

`ifdef FAIR_ARB_EN
    grant_t              r_last_grant;
`endif

    mem_arb_pick u_pick (
        .i_if_req     (if_req),
        .i_dm_req     (dm_req),
`ifdef FAIR_ARB_EN
        .i_last_grant (r_last_grant),
`endif
        .o_any        (w_any),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE is a dead cycle for arbitration so the served requester can drop its request.
    always_comb begin
        w_state_next = r_state;
        w_grant_load = 1'b0;
        w_xfer_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_load = 1'b1;
                    w_state_next = (w_grant == GRANT_DM) ? DM_XFER : IF_XFER;
                end
            end
            IF_XFER, DM_XFER: begin
                if (mem_ack) begin
                    w_xfer_done  = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (w_grant_load) begin
                r_mem_req <= 1'b1;
                if (w_grant == GRANT_DM) begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end
            if (w_xfer_done) begin
                r_mem_req <= 1'b0;
                if (r_state == IF_XFER) begin
                    r_if_rdata <= mem_rdata;
                    r_if_ready <= 1'b1;
                end else begin
                    r_dm_ready <= 1'b1;
                    if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

`ifdef FAIR_ARB_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_grant <= GRANT_IF;
        end else if (w_grant_load) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_ready  = r_if_ready;
    assign dm_ready  = r_dm_ready;
    assign stall     = (if_req & ~r_if_ready) | (dm_req & ~r_dm_ready);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held by requester until if_ready.
REQ-006 if_addr  in  ADDR_W  fetch address.
REQ-007 if_rdata  out  DATA_W  fetched word, registered.
REQ-008 if_ready  out  1  one-cycle pulse, fetch complete.
REQ-009 dm_req  in  1  data request; held until dm_ready.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  ADDR_W  data address.
REQ-012 dm_wdata  in  DATA_W  store data.
REQ-013 dm_rdata  out  DATA_W  load word, registered.
REQ-014 dm_ready  out  1  one-cycle pulse, data access complete.
REQ-015 mem_req  out  1  memory request, registered.
REQ-016 mem_we  out  1  memory write enable, registered.
REQ-017 mem_addr  out  ADDR_W  memory address, registered.
REQ-018 mem_wdata  out  DATA_W  memory write data, registered.
REQ-019 mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
REQ-020 mem_ack  in  1  memory completion, variable latency >= 1 cycle.
REQ-021 stall  out  1  pipeline freeze = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.

Function
REQ-022 FSM states: IDLE, IF_XFER, DM_XFER, DONE.
REQ-023 IDLE: no request -> stay; grant per REQ-030/031; on grant, latch address/we/wdata into mem_* registers, set mem_req=1, go to IF_XFER or DM_XFER (mem_req visible cycle after request sampled).
REQ-024 IF_XFER/DM_XFER: mem_req, mem_addr, mem_we, mem_wdata held stable until mem_ack sampled high.
REQ-025 On mem_ack in XFER: mem_req=0 next cycle; read data captured into if_rdata (fetch) or dm_rdata (load only); go to DONE.
REQ-026 DONE: pulse if_ready or dm_ready for the served requester for exactly one cycle; no new grant; go to IDLE.
REQ-027 Minimum request-to-ready latency 3 cycles (mem_ack on first mem_req cycle); ready never asserted for both requesters in one cycle.
REQ-028 mem_ack in IDLE or DONE ignored; store does not alter dm_rdata.
REQ-029 Requester dropping req during XFER: transfer completes, ready still pulses.
REQ-030 Default arbitration: dm_req wins simultaneous requests (older instruction).
REQ-031 Fetch fetches mem_we=0 always.

Reset
REQ-032 reset=1 at a clock edge: state IDLE; mem_req, mem_we, if_ready, dm_ready = 0; mem_addr, mem_wdata, if_rdata, dm_rdata = 0; last-grant = IF.
REQ-033 Reset mid-transfer aborts it: no ready pulse; a mem_ack arriving afterwards in IDLE is ignored.

Configuration
REQ-034 Macro FAIR_ARB_EN defined: on simultaneous requests the requester not granted last wins; last-grant register updated on every grant.
REQ-035 FAIR_ARB_EN undefined: fixed dm priority per REQ-030; last-grant register absent.

Structure
REQ-036 Package mem_arb_pkg holds state encoding (IDLE, IF_XFER, DM_XFER, DONE) and grant constants GRANT_IF, GRANT_DM.
REQ-037 Combinational sub-module mem_arb_pick selects grant from if_req, dm_req, last-grant; contains the FAIR_ARB_EN selection.

Verification
REQ-038 if_req only, if_addr=0x00000010, mem_ack 1 cycle after mem_req, mem_rdata=0x8C220004 -> mem_addr=0x10, mem_we=0; if_ready pulse with if_rdata=0x8C220004; stall low after.
REQ-039 if_req and dm_req same cycle, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> dm served first (mem_we=1, mem_wdata=0xDEADBEEF), then fetch; dm_rdata unchanged.
REQ-040 mem_ack delayed 5 cycles on load dm_addr=0x80 -> mem_* stable all 5 cycles, stall=1 throughout, dm_ready exactly one cycle.
REQ-041 reset asserted in DM_XFER, mem_ack next cycle -> mem_req=0, no dm_ready, all outputs 0, state IDLE.
REQ-042 FAIR_ARB_EN defined, both requests held continuously for 4 transactions -> grants DM, IF, DM, IF; undefined -> DM repeatedly while dm_req held.
